hazard_forward_unit: RTL and testbench

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/riscv_pipe_pkg.sv | 30 +++
 rtl/fwd_sel_cmp.sv | 21 ++
 rtl/hazard_forward_unit.sv | 108 ++++++++++
 tb/tb_hazard_forward_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and constants for the hazard/forwarding logic.
// Holds the shadow-stage records and the operand-mux select encodings.
package riscv_pipe_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Destination record tracked by MEM and WB
    typedef struct packed {
        reg_addr_t rd;
        logic      rw;
    } shadow_rec_t;

    typedef struct packed {
        reg_addr_t   rs1;
        reg_addr_t   rs2;
        shadow_rec_t dst;
        logic        mr;
    } ex_rec_t;

    function automatic logic dst_hit(shadow_rec_t s, reg_addr_t rs);
        return s.rw && (s.rd != '0) && (s.rd == rs);
    endfunction

endpackage

// File: rtl/fwd_sel_cmp.sv
// Per-operand forwarding select: MEM result beats WB result beats regfile.
// x0 never hits, so it always reads from the register file.
module fwd_sel_cmp
    import riscv_pipe_pkg::*;
(
    input  reg_addr_t   rs_i,
    input  shadow_rec_t mem_i,
    input  shadow_rec_t wb_i,
    output logic [1:0]  sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (dst_hit(mem_i, rs_i)) begin
            sel_o = FWD_MEM;
        end else if (dst_hit(wb_i, rs_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use stall and EX operand forwarding from a shadow EX/MEM/WB pipeline.
// Define FWD_PERF_CNT_EN to add saturating stall_cnt/fwd_cnt counters.
module hazard_forward_unit
    import riscv_pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           fwd_cnt
`endif
);

    ex_rec_t     ex_q,  ex_d;
    shadow_rec_t mem_q, mem_d;
    shadow_rec_t wb_q,  wb_d;

    logic ex_load_hit;

    // A load still in EX cannot feed the instruction now in ID
    always_comb begin
        ex_load_hit = ex_q.mr
                   && (ex_q.dst.rd != '0)
                   && ((ex_q.dst.rd == id_rs1) || (ex_q.dst.rd == id_rs2));
        stall = id_valid && !flush && ex_load_hit;
    end

    always_comb begin
        ex_d = '0;
        if (id_valid && !stall && !flush) begin
            ex_d.rs1    = id_rs1;
            ex_d.rs2    = id_rs2;
            ex_d.dst.rd = id_rd;
            ex_d.dst.rw = id_reg_write;
            ex_d.mr     = id_mem_read;
        end
        mem_d = ex_q.dst;
        wb_d  = mem_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    fwd_sel_cmp u_fwd_a (
        .rs_i  (ex_q.rs1),
        .mem_i (mem_q),
        .wb_i  (wb_q),
        .sel_o (fwd_a_sel)
    );

    fwd_sel_cmp u_fwd_b (
        .rs_i  (ex_q.rs2),
        .mem_i (mem_q),
        .wb_i  (wb_q),
        .sel_o (fwd_b_sel)
    );

`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q,   fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (((fwd_a_sel != FWD_RF) || (fwd_b_sel != FWD_RF))
            && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Randomized + directed bench for hazard_forward_unit against a
// history-queue model of what entered EX over the last three cycles.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_reg_write, id_mem_read;
    logic       flush;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall;
`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt, fwd_cnt;
`endif

    int checks = 0;
    int errors = 0;

    hazard_forward_unit dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall)
`ifdef FWD_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .fwd_cnt      (fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int rs1;
        int rs2;
        int rd;
        bit rw;
        bit mr;
    } instr_t;

    // hist[0] = in EX, hist[1] = in MEM, hist[2] = in WB
    instr_t hist[$];
    longint m_stall_cnt;
    longint m_fwd_cnt;

    function automatic instr_t nop_i();
        instr_t n;
        n.rs1 = 0; n.rs2 = 0; n.rd = 0; n.rw = 0; n.mr = 0;
        return n;
    endfunction

    function automatic bit produces(instr_t p, int rs);
        return p.rw && p.rd != 0 && p.rd == rs;
    endfunction

    function automatic int exp_sel(int rs);
        if (produces(hist[1], rs)) return 2;
        if (produces(hist[2], rs)) return 1;
        return 0;
    endfunction

    function automatic bit exp_stall();
        instr_t e = hist[0];
        return id_valid && !flush && e.mr && e.rd != 0
            && (e.rd == int'(id_rs1) || e.rd == int'(id_rs2));
    endfunction

    task automatic model_reset();
        hist.delete();
        repeat (3) hist.push_back(nop_i());
        m_stall_cnt = 0;
        m_fwd_cnt   = 0;
    endtask

    task automatic model_edge();
        instr_t n;
        bit st, fw;
        if (rst) begin
            model_reset();
        end else begin
            st = exp_stall();
            fw = exp_sel(hist[0].rs1) != 0 || exp_sel(hist[0].rs2) != 0;
            if (st && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
            if (fw && m_fwd_cnt < 64'hFFFF_FFFF) m_fwd_cnt++;
            n = nop_i();
            if (id_valid && !st && !flush) begin
                n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
                n.rw = id_reg_write; n.mr = id_mem_read;
            end
            hist.push_front(n);
            void'(hist.pop_back());
        end
    endtask

    task automatic chk(string nm, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, required %0d", nm, $time, act, req);
        end
    endtask

    task automatic cmp_model();
        chk("model_a_sel", fwd_a_sel, exp_sel(hist[0].rs1));
        chk("model_b_sel", fwd_b_sel, exp_sel(hist[0].rs2));
        chk("model_stall", stall, exp_stall());
`ifdef FWD_PERF_CNT_EN
        chk("model_stall_cnt", stall_cnt, m_stall_cnt);
        chk("model_fwd_cnt", fwd_cnt, m_fwd_cnt);
`endif
    endtask

    task automatic lit(string nm, int a, int b, int s);
        chk({nm, "_a"}, fwd_a_sel, a);
        chk({nm, "_b"}, fwd_b_sel, b);
        chk({nm, "_stall"}, stall, s);
    endtask

    // One cycle: edge, drive new inputs, compare at the falling edge
    task automatic cyc(bit r, bit v, int a, int b, int d,
                       bit w, bit m, bit f);
        @(posedge clk);
        model_edge();
        #1;
        rst = r; id_valid = v;
        id_rs1 = 5'(a); id_rs2 = 5'(b); id_rd = 5'(d);
        id_reg_write = w; id_mem_read = m; flush = f;
        @(negedge clk);
        cmp_model();
    endtask

    task automatic idle(int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
    endtask

    initial begin
        rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_reg_write = 0; id_mem_read = 0; flush = 0;
        model_reset();
        do_reset();
        lit("reset", 0, 0, 0);

        // add x5 ; sub x6,x5,x1
        cyc(0, 1, 1, 2, 5, 1, 0, 0);
        cyc(0, 1, 5, 1, 6, 1, 0, 0);
        idle(1);
        lit("ex_mem_fwd", 2, 0, 0);
        idle(3);

        // add x5 ; nop ; sub x6,x1,x5
        cyc(0, 1, 1, 2, 5, 1, 0, 0);
        idle(1);
        cyc(0, 1, 1, 5, 6, 1, 0, 0);
        idle(1);
        lit("wb_fwd", 0, 1, 0);
        idle(3);

        // add x5 ; add x5 ; sub x7,x5,x5
        cyc(0, 1, 1, 2, 5, 1, 0, 0);
        cyc(0, 1, 3, 4, 5, 1, 0, 0);
        cyc(0, 1, 5, 5, 7, 1, 0, 0);
        idle(1);
        lit("mem_prio", 2, 2, 0);
        idle(3);

        // lw x8 ; add x9,x8,x8 -> one stall, then WB forward
        do_reset();
        cyc(0, 1, 1, 0, 8, 1, 1, 0);
        cyc(0, 1, 8, 8, 9, 1, 0, 0);
        lit("load_use", 0, 0, 1);
        cyc(0, 1, 8, 8, 9, 1, 0, 0);
        lit("load_use_rel", 0, 0, 0);
        idle(1);
        lit("load_use_fwd", 1, 1, 0);
`ifdef FWD_PERF_CNT_EN
        chk("lit_stall_cnt", stall_cnt, 1);
`endif
        idle(3);

        // back-to-back loads to x8, each used
        cyc(0, 1, 1, 0, 8, 1, 1, 0);
        cyc(0, 1, 8, 0, 9, 1, 0, 0);
        lit("b2b_1", 0, 0, 1);
        cyc(0, 1, 8, 0, 9, 1, 0, 0);
        cyc(0, 1, 2, 0, 8, 1, 1, 0);
        cyc(0, 1, 0, 8, 10, 1, 0, 0);
        lit("b2b_2", 0, 0, 1);
        cyc(0, 1, 0, 8, 10, 1, 0, 0);
        lit("b2b_2_rel", 0, 0, 0);
        idle(3);

        // x0 is never forwarded
        cyc(0, 1, 1, 2, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 3, 1, 0, 0);
        idle(1);
        lit("x0", 0, 0, 0);
        idle(3);

        // flush beats stall
        cyc(0, 1, 1, 0, 8, 1, 1, 0);
        cyc(0, 1, 8, 8, 9, 1, 0, 1);
        lit("flush", 0, 0, 0);
        idle(3);

        // reset during the stall cycle
        cyc(0, 1, 1, 0, 8, 1, 1, 0);
        cyc(1, 1, 8, 8, 9, 1, 0, 0);
        lit("rst_stall", 0, 0, 1);
        cyc(0, 1, 8, 8, 9, 1, 0, 0);
        lit("rst_clear", 0, 0, 0);
`ifdef FWD_PERF_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_fwd_cnt", fwd_cnt, 0);
`endif
        idle(3);

        // randomized traffic over a small register range
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(99) < 2,
                $urandom_range(99) < 80,
                $urandom_range(7), $urandom_range(7), $urandom_range(7),
                $urandom_range(99) < 70,
                $urandom_range(99) < 35,
                $urandom_range(99) < 8);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
